fpga_cfg_loader: RTL and testbench

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_pkg.sv | 25 ++
 rtl/fpga_cfg_pclk_div.sv | 26 ++
 rtl/fpga_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - register offsets, bit indices and FSM states for fpga_cfg_loader
package fpga_cfg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_TAIL   = 2'd3;

  localparam int CTRL_PROG_RESET = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_CLR_DONE   = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_BUF_FULL  = 1;
  localparam int STAT_DONE      = 2;
  localparam int STAT_WORDS_LSB = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/fpga_cfg_pclk_div.sv
// rtl/fpga_cfg_pclk_div.sv - prog_clk half-period counter, strobes on the last cycle of each phase
module fpga_cfg_pclk_div #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_end
);

  logic [7:0] cnt;

  assign phase_end = en && (cnt == 8'(PCLK_DIV - 1));

  // Restart at every phase boundary and whenever the shifter is not clocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - Wishbone-driven serial fabric configuration loader; CFG_LOADER_IRQ_EN enables cfg_irq
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int PCLK_DIV = 2,
  parameter int WORD_W   = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        prog_clk,
  output logic        prog_reset,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        cfg_irq
);

  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  cfg_state_t        state;
  logic [WORD_W-1:0] buf_reg, shift_reg, tail_reg;
  logic [BCW-1:0]    bitcnt;
  logic [15:0]       words_shifted;
  logic              buf_full, done, hi_first, irq_en;
  logic              req, wr_ok, data_wr, accept, ctrl_wr, kill, clr_done, phase_end, div_en;
  logic [1:0]        reg_sel;
  logic [31:0]       rdata;
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};
  assign reg_sel    = wbs_adr_i[3:2];
  assign req        = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign wr_ok      = wbs_we_i && (wbs_sel_i == 4'hF);
  assign data_wr    = req && wr_ok && (reg_sel == REG_DATA);
  // LOAD empties the buffer this cycle, so a waiting word may land at the same edge.
  assign accept     = req && !(data_wr && buf_full && (state != LOAD));
  assign ctrl_wr    = accept && wr_ok && (reg_sel == REG_CTRL);
  assign kill       = ctrl_wr && wbs_dat_i[CTRL_PROG_RESET];
  assign clr_done   = ctrl_wr && wbs_dat_i[CTRL_CLR_DONE];
  assign div_en     = (state == LOW) || (state == HIGH);

  fpga_cfg_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_pclk_div (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .en        (div_en),
    .phase_end (phase_end)
  );

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_PROG_RESET] = prog_reset;
        rdata[CTRL_IRQ_EN]     = irq_en;
      end
      REG_STATUS: begin
        rdata[STAT_BUSY]             = (state != IDLE);
        rdata[STAT_BUF_FULL]         = buf_full;
        rdata[STAT_DONE]             = done;
        rdata[31:STAT_WORDS_LSB]     = words_shifted;
      end
      REG_TAIL: rdata[WORD_W-1:0] = tail_reg;
      default: ;
    endcase
  end

`ifndef CFG_LOADER_IRQ_EN
  assign irq_en  = 1'b0;
  assign cfg_irq = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      buf_reg       <= '0;
      shift_reg     <= '0;
      tail_reg      <= '0;
      bitcnt        <= '0;
      words_shifted <= '0;
      buf_full      <= 1'b0;
      done          <= 1'b0;
      hi_first      <= 1'b0;
      prog_clk      <= 1'b0;
      ccff_head     <= 1'b0;
      prog_reset    <= 1'b1;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
`ifdef CFG_LOADER_IRQ_EN
      irq_en        <= 1'b0;
      cfg_irq       <= 1'b0;
`endif
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
      hi_first  <= 1'b0;
      if (ctrl_wr) begin
        prog_reset <= wbs_dat_i[CTRL_PROG_RESET];
`ifdef CFG_LOADER_IRQ_EN
        irq_en     <= wbs_dat_i[CTRL_IRQ_EN];
`endif
      end
      if (clr_done) done <= 1'b0;

      case (state)
        IDLE: if (buf_full && !prog_reset) state <= LOAD;
        LOAD: begin
          shift_reg <= buf_reg;
          buf_full  <= 1'b0;
          bitcnt    <= '0;
          ccff_head <= buf_reg[WORD_W-1];
          state     <= LOW;
        end
        LOW: if (phase_end) begin
          prog_clk <= 1'b1;
          hi_first <= 1'b1;
          state    <= HIGH;
        end
        HIGH: begin
          if (hi_first) tail_reg <= {tail_reg[WORD_W-2:0], ccff_tail};
          if (phase_end) begin
            prog_clk  <= 1'b0;
            shift_reg <= shift_reg << 1;
            if (bitcnt == LAST_BIT) begin
              if (words_shifted != 16'hFFFF) words_shifted <= words_shifted + 16'd1;
              done      <= 1'b1;
              ccff_head <= 1'b0;
              state     <= buf_full ? LOAD : IDLE;
            end else begin
              bitcnt    <= bitcnt + 1'b1;
              ccff_head <= shift_reg[WORD_W-2];
              state     <= LOW;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (data_wr && accept) begin
        buf_reg  <= wbs_dat_i[WORD_W-1:0];
        buf_full <= 1'b1;
      end

      // Entering configuration reset abandons the word in flight and all progress.
      if (kill) begin
        state         <= IDLE;
        buf_reg       <= '0;
        buf_full      <= 1'b0;
        shift_reg     <= '0;
        bitcnt        <= '0;
        words_shifted <= '0;
        done          <= 1'b0;
        prog_clk      <= 1'b0;
        ccff_head     <= 1'b0;
      end
`ifdef CFG_LOADER_IRQ_EN
      cfg_irq <= done && irq_en;
`endif
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader (honours CFG_LOADER_IRQ_EN)
module tb_fpga_cfg_loader;
  import fpga_cfg_pkg::*;

  localparam int PD = 2;
  localparam int W  = 32;
`ifdef CFG_LOADER_IRQ_EN
  localparam logic [31:0] IRQ_RD = 32'h2;
`else
  localparam logic [31:0] IRQ_RD = 32'h0;
`endif

  logic        clk, rst, stb, cyc, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        prog_clk, prog_reset, ccff_head, ccff_tail, cfg_irq;

  int checks = 0, errors = 0, cycle = 0, pulses = 0;
  int first_rise = -1, last_fall = -1, irq_rise = -1, irq_hi = 0;
  logic        bit_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        prev_pclk = 1'b0, prev_irq = 1'b0, prev_head = 1'b0, prev_exp_bit = 1'b0, exp_bit;
  logic [31:0] exp_tail = '0;

  fpga_cfg_loader #(.PCLK_DIV(PD), .WORD_W(W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_w),
    .wbs_dat_o  (dat_r),
    .wbs_ack_o  (ack),
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .cfg_irq    (cfg_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cycle++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cycle);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int lat, output int c);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 1000);
    check("ack_seen", {31'd0, ack}, 32'd1);
    rd = dat_r;
    c  = cycle;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output int c);
    logic [31:0] rd;
    if (a[3:2] == REG_DATA && s == 4'hF)
      for (int i = W - 1; i >= 0; i--) bit_q.push_back(d[i]);
    wb_cycle(1'b1, a, d, s, rd, lat, c);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat, c;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    wb_cycle(1'b0, a, 32'd0, 4'hF, rd, lat, c);
    check({tag, "_lat"}, lat, 32'd1);
    check(tag_q.pop_front(), rd, exp_q.pop_front());
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (pulses < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pulse_wait", pulses, target);
  endtask

  // Output monitor: bit-stream scoreboard, edge timing and ccff_tail loopback one prog_clk behind head.
  initial begin
    ccff_tail = 1'b0;
    forever begin
      @(negedge clk);
      if (prog_clk && !prev_pclk) begin
        pulses++;
        if (first_rise < 0) first_rise = cycle;
        if (bit_q.size() > 0) begin
          exp_bit = bit_q.pop_front();
          check("head_bit", {31'd0, ccff_head}, {31'd0, exp_bit});
          exp_tail     = {exp_tail[30:0], prev_exp_bit};
          prev_exp_bit = exp_bit;
        end
        ccff_tail = prev_head;
        prev_head = ccff_head;
      end
      if (!prog_clk && prev_pclk) last_fall = cycle;
      if (cfg_irq && !prev_irq) irq_rise = cycle;
      if (cfg_irq) irq_hi++;
      prev_pclk = prog_clk;
      prev_irq  = cfg_irq;
    end
  end

  initial begin
    int lat, c1, c2, c3, p, base;
    logic [31:0] w1, w2, w3;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {27'd0, ack, prog_clk, ccff_head, cfg_irq, prog_reset}, 32'h1);
    check("rst_dat_o", dat_r, 32'h0);
    rst = 1'b0;

    wb_read("ctrl_rst", 32'h0, 32'h1);
    wb_read("status_rst", 32'h4, 32'h0);
    wb_read("tail_rst", 32'hC, 32'h0);

    // Partial byte select on DATA is acknowledged but discarded.
    wb_write(32'h8, 32'hFFFF_FFFF, 4'h3, lat, c1);
    check("sel_partial_lat", lat, 32'd1);
    wb_read("status_sel", 32'h4, 32'h0);

    wb_write(32'h0, 32'h2, 4'hF, lat, c1);
    check("prog_reset_low", {31'd0, prog_reset}, 32'd0);
    wb_read("ctrl_irq_en", 32'h0, IRQ_RD);

    // Single word, MSB first.
    base = pulses; first_rise = -1;
    wb_write(32'h8, 32'hA500_0001, 4'hF, lat, c1);
    check("data_lat", lat, 32'd1);
    wait_pulses(base + W);
    repeat (2 * PD + 4) @(posedge clk);
    #1;
    check("first_rise", first_rise, c1 + 2 + PD);
    check("word_end", last_fall, c1 + 1 + (1 + 2 * PD * W));
    check("idle_outs", {30'd0, prog_clk, ccff_head}, 32'd0);
    wb_read("status_word1", 32'h4, 32'h0001_0004);
    wb_read("tail_word1", 32'hC, exp_tail);
    wb_read("data_rd_zero", 32'h8, 32'h0);

`ifdef CFG_LOADER_IRQ_EN
    check("irq_latency", irq_rise, last_fall + 1);
    check("irq_high", {31'd0, cfg_irq}, 32'd1);
`endif
    wb_write(32'h0, 32'h6, 4'hF, lat, c1);
    @(posedge clk); #1;
    check("irq_after_clr", {31'd0, cfg_irq}, 32'd0);
    wb_read("status_clr", 32'h4, 32'h0001_0000);
    wb_read("ctrl_clr_rd", 32'h0, IRQ_RD);

    // Three back-to-back words: second lands during LOAD, third waits a word.
    wb_write(32'h0, 32'h1, 4'hF, lat, c1);
    wb_write(32'h0, 32'h2, 4'hF, lat, c1);
    wb_read("status_kill", 32'h4, 32'h0);
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    base = pulses; first_rise = -1;
    wb_write(32'h8, w1, 4'hF, lat, c1);
    check("b2b_w1_lat", lat, 32'd1);
    wb_write(32'h8, w2, 4'hF, lat, c2);
    check("b2b_w2_lat", lat, 32'd1);
    wb_write(32'h8, w3, 4'hF, lat, c3);
    check("b2b_w3_ack", c3, c1 + 3 + 2 * PD * W);
    wait_pulses(base + 3 * W);
    repeat (2 * PD + 4) @(posedge clk);
    #1;
    check("b2b_first_rise", first_rise, c1 + 2 + PD);
    check("b2b_end", last_fall, c1 + 1 + 3 * (1 + 2 * PD * W));
    wb_read("status_b2b", 32'h4, 32'h0003_0004);
    wb_read("tail_b2b", 32'hC, exp_tail);

    // Abort mid-word with prog_reset.
    base = pulses;
    wb_write(32'h8, $urandom, 4'hF, lat, c1);
    wait_pulses(base + 10);
    wb_write(32'h0, 32'h3, 4'hF, lat, c1);
    check("kill_outs", {29'd0, prog_reset, prog_clk, ccff_head}, 32'h4);
    bit_q.delete();
    p = pulses;
    wb_read("status_kill_mid", 32'h4, 32'h0);
    wb_write(32'h0, 32'h2, 4'hF, lat, c1);
    repeat (20) @(posedge clk);
    #1;
    check("kill_no_pulses", pulses, p);
    wb_read("status_after_release", 32'h4, 32'h0);

`ifndef CFG_LOADER_IRQ_EN
    check("irq_never", irq_hi, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
